// File: rtl/mysoc_ram_copy_master.sv
// Avalon-MM copy master: moves a block of 32-bit words from src to dst
// using single-word reads and writes, one read outstanding at a time.
module mysoc_ram_copy_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   src_nxt;
    logic [ADDR_W-1:0]   dst;
    logic [ADDR_W-1:0]   dst_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    rem_nxt;
    logic [LEN_W-1:0]    words_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    assign avm_byteenable = '1;

    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        dst_nxt   = dst;
        rem_nxt   = rem;
        words_nxt = words_done;
        addr_nxt  = avm_address;
        wdata_nxt = avm_writedata;
        unique case (state)
            IDLE: begin
                if (start) begin
                    src_nxt   = src_addr & ALIGN_MASK;
                    dst_nxt   = dst_addr & ALIGN_MASK;
                    rem_nxt   = len;
                    words_nxt = '0;
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RD_REQ;
                        addr_nxt  = src_addr & ALIGN_MASK;
                    end
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    wdata_nxt = avm_readdata;
                    addr_nxt  = dst;
                    state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    words_nxt = words_done + LEN_W'(1);
                    src_nxt   = src + WORD_BYTES;
                    dst_nxt   = dst + WORD_BYTES;
                    rem_nxt   = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RD_REQ;
                        addr_nxt  = src + WORD_BYTES;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they leave a flop
    // in the same cycle the state register enters the matching state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            rem           <= '0;
            words_done    <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            src           <= src_nxt;
            dst           <= dst_nxt;
            rem           <= rem_nxt;
            words_done    <= words_nxt;
            avm_address   <= addr_nxt;
            avm_writedata <= wdata_nxt;
            avm_read      <= (state_nxt == RD_REQ);
            avm_write     <= (state_nxt == WR_REQ);
            busy          <= (state_nxt == RD_REQ) ||
                             (state_nxt == RD_WAIT) ||
                             (state_nxt == WR_REQ);
            done          <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_mysoc_ram_copy_master.sv
// Directed bench for mysoc_ram_copy_master with a latency-1 memory
// responder and programmable per-request waitrequest stalls.
module tb_mysoc_ram_copy_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_waitrequest;

    int passed = 0;
    int total = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int stall_cycles = 0;
    int wait_cnt = 0;
    int stall_viol = 0;
    int conflicts = 0;
    bit held = 1'b0;
    logic [31:0] h_addr;
    logic [31:0] h_wd;
    logic h_rd;
    logic h_wr;

    always #5 clk = ~clk;

    mysoc_ram_copy_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len               (len),
        .busy              (busy),
        .done              (done),
        .words_done        (words_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    assign avm_waitrequest = (avm_read || avm_write) &&
                             (wait_cnt < stall_cycles);

    // Slave model: stalls each request, answers reads one cycle later.
    always @(posedge clk) begin
        if (avm_read && avm_write) conflicts++;
        if (held) begin
            if (avm_address !== h_addr || avm_read !== h_rd ||
                avm_write !== h_wr || avm_writedata !== h_wd)
                stall_viol++;
        end
        held = (avm_read || avm_write) && avm_waitrequest;
        h_addr = avm_address;
        h_rd = avm_read;
        h_wr = avm_write;
        h_wd = avm_writedata;
        if ((avm_read || avm_write) && avm_waitrequest)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
        if (avm_read && !avm_waitrequest) begin
            rd_addr_q.push_back(avm_address);
            avm_readdatavalid <= 1'b1;
            avm_readdata <= mem.exists(avm_address) ?
                            mem[avm_address] : 32'hDEAD_BEEF;
        end else begin
            avm_readdatavalid <= 1'b0;
        end
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address] = avm_writedata;
            wr_addr_q.push_back(avm_address);
            wr_data_q.push_back(avm_writedata);
        end
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        stall_viol = 0;
        conflicts = 0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input bit poke,
                            output int done_at, output int first_rd,
                            output int busy_bad);
        int n;
        done_at = -1;
        first_rd = -1;
        busy_bad = 0;
        clear_logs();
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len = l;
        start = 1'b1;
        n = 0;
        while (done_at < 0 && n < 400) begin
            @(negedge clk);
            n++;
            start = poke && (n == 2 || n == 5 || n == 8);
            if (start) begin
                src_addr = 32'h0000_0F00;
                len = 16'd7;
            end
            if (avm_read === 1'b1 && first_rd < 0) first_rd = n;
            if (done === 1'b1) begin
                done_at = n;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        start = 1'b0;
        if (done_at < 0) begin
            total++;
            $display("FAIL copy_timeout: no done after %0d cycles", n);
        end else begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({words_done, avm_address, avm_writedata} !== 80'h0)
            $display("FAIL reset_regs: got %h/%h/%h want 0",
                     words_done, avm_address, avm_writedata);
        else passed++;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, avm_read, avm_write, avm_byteenable} !== 8'h0F)
                $display("FAIL reset_idle[%0d]: got %b want 00001111", i,
                         {busy, done, avm_read, avm_write, avm_byteenable});
            else passed++;
        end
    endtask

    task automatic check_basic_copy(input string tag, input int da,
                                    input int want_da, input int bb);
        total++;
        if (da !== want_da)
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, da, want_da);
        else passed++;
        total++;
        if (bb !== 0)
            $display("FAIL %s_busy_done: got %0d bad cycles want 0", tag, bb);
        else passed++;
        total++;
        if (words_done !== 16'd4)
            $display("FAIL %s_words_done: got %0d want 4", tag, words_done);
        else passed++;
        total++;
        if (rd_addr_q.size() != 4 || wr_addr_q.size() != 4)
            $display("FAIL %s_counts: got %0d rd %0d wr want 4 4", tag,
                     rd_addr_q.size(), wr_addr_q.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_addr_q[i] !== 32'(4 * i) ||
                wr_addr_q[i] !== 32'h100 + 32'(4 * i) ||
                wr_data_q[i] !== 32'hA1 + 32'(i))
                $display("FAIL %s_word%0d: got rd %h wr %h data %h want %h %h %h",
                         tag, i, rd_addr_q[i], wr_addr_q[i], wr_data_q[i],
                         32'(4 * i), 32'h100 + 32'(4 * i), 32'hA1 + 32'(i));
            else passed++;
        end
        total++;
        if (conflicts !== 0)
            $display("FAIL %s_rd_wr_overlap: got %0d want 0", tag, conflicts);
        else passed++;
    endtask

    task automatic test_basic();
        int da, fr, bb;
        mem.delete();
        for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'hA1 + 32'(i);
        stall_cycles = 0;
        run_copy(32'h0, 32'h100, 16'd4, 1'b0, da, fr, bb);
        total++;
        if (fr !== 1)
            $display("FAIL basic_first_read: got %0d want 1", fr);
        else passed++;
        check_basic_copy("basic", da, 13, bb);
    endtask

    task automatic test_backpressure();
        int da, fr, bb;
        mem.delete();
        for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'hA1 + 32'(i);
        stall_cycles = 2;
        run_copy(32'h0, 32'h100, 16'd4, 1'b0, da, fr, bb);
        stall_cycles = 0;
        total++;
        if (stall_viol !== 0)
            $display("FAIL bp_hold_stable: got %0d changes want 0", stall_viol);
        else passed++;
        check_basic_copy("bp", da, 29, bb);
    endtask

    task automatic test_zero_len();
        int da, fr, bb;
        run_copy(32'h40, 32'h80, 16'd0, 1'b0, da, fr, bb);
        total++;
        if (da !== 1 || bb !== 0)
            $display("FAIL zero_done: got cycle %0d bad %0d want 1 0", da, bb);
        else passed++;
        total++;
        if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || fr != -1)
            $display("FAIL zero_bus: got %0d rd %0d wr want 0 0",
                     rd_addr_q.size(), wr_addr_q.size());
        else passed++;
        total++;
        if (words_done !== 16'd0)
            $display("FAIL zero_words: got %0d want 0", words_done);
        else passed++;
    endtask

    task automatic test_busy_start();
        int da, fr, bb;
        for (int i = 0; i < 3; i++) mem[32'h10 + 32'(4 * i)] = 32'hB1 + 32'(i);
        run_copy(32'h10, 32'h700, 16'd3, 1'b1, da, fr, bb);
        total++;
        if (da !== 10 || bb !== 0)
            $display("FAIL busy_start_done: got cycle %0d bad %0d want 10 0",
                     da, bb);
        else passed++;
        total++;
        if (wr_addr_q.size() != 3 || words_done !== 16'd3)
            $display("FAIL busy_start_count: got %0d writes words %0d want 3 3",
                     wr_addr_q.size(), words_done);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_addr_q[i] !== 32'h700 + 32'(4 * i) ||
                wr_data_q[i] !== 32'hB1 + 32'(i))
                $display("FAIL busy_start_word%0d: got %h %h want %h %h", i,
                         wr_addr_q[i], wr_data_q[i],
                         32'h700 + 32'(4 * i), 32'hB1 + 32'(i));
            else passed++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || avm_read !== 1'b0 || rd_addr_q.size() != 3)
            $display("FAIL busy_start_queued: got busy %b reads %0d want 0 3",
                     busy, rd_addr_q.size());
        else passed++;
    endtask

    task automatic test_wrap();
        int da, fr, bb;
        mem.delete();
        mem[32'h0] = 32'h1111_1111;
        mem[32'h4] = 32'h2222_2222;
        run_copy(32'h3, 32'hFFFF_FFFC, 16'd2, 1'b0, da, fr, bb);
        total++;
        if (da !== 7 || bb !== 0)
            $display("FAIL wrap_done: got cycle %0d bad %0d want 7 0", da, bb);
        else passed++;
        total++;
        if (rd_addr_q[0] !== 32'h0 || rd_addr_q[1] !== 32'h4)
            $display("FAIL wrap_reads: got %h %h want 0 4",
                     rd_addr_q[0], rd_addr_q[1]);
        else passed++;
        total++;
        if (wr_addr_q[0] !== 32'hFFFF_FFFC || wr_addr_q[1] !== 32'h0)
            $display("FAIL wrap_writes: got %h %h want fffffffc 0",
                     wr_addr_q[0], wr_addr_q[1]);
        else passed++;
        total++;
        if (wr_data_q[0] !== 32'h1111_1111 || wr_data_q[1] !== 32'h2222_2222)
            $display("FAIL wrap_data: got %h %h want 11111111 22222222",
                     wr_data_q[0], wr_data_q[1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n, da, fr, bb;
        mem.delete();
        for (int i = 0; i < 5; i++) mem[32'h300 + 32'(4 * i)] = 32'hC1 + 32'(i);
        mem[32'h500] = 32'hD1;
        mem[32'h504] = 32'hD2;
        clear_logs();
        @(negedge clk);
        src_addr = 32'h300;
        dst_addr = 32'h400;
        len = 16'd5;
        start = 1'b1;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(avm_write === 1'b1 && words_done === 16'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100)
            $display("FAIL mid_reach_word2: got no second write want one");
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({avm_write, avm_read, busy, done} !== 4'b0 ||
            words_done !== 16'd0 || avm_address !== 32'h0)
            $display("FAIL mid_async_reset: got wr %b rd %b busy %b words %0d addr %h want all 0",
                     avm_write, avm_read, busy, words_done, avm_address);
        else passed++;
        total++;
        if (wr_addr_q.size() != 1 || mem[32'h400] !== 32'hC1 ||
            mem.exists(32'h404))
            $display("FAIL mid_partial_dst: got %0d writes dst0 %h want 1 c1",
                     wr_addr_q.size(), mem[32'h400]);
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_copy(32'h500, 32'h600, 16'd2, 1'b0, da, fr, bb);
        total++;
        if (da !== 7 || bb !== 0 || words_done !== 16'd2)
            $display("FAIL mid_restart: got cycle %0d bad %0d words %0d want 7 0 2",
                     da, bb, words_done);
        else passed++;
        total++;
        if (wr_addr_q[0] !== 32'h600 || wr_addr_q[1] !== 32'h604 ||
            wr_data_q[0] !== 32'hD1 || wr_data_q[1] !== 32'hD2)
            $display("FAIL mid_restart_data: got %h=%h %h=%h want 600=d1 604=d2",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_busy_start();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mysoc_ram_copy_master.md
Name: mysoc_ram_copy_master

Overview:
Avalon-MM master that moves a block of 32-bit words from a source byte address to a destination byte address. It issues single-word reads and writes with byte enables all 4'hF. It drives the initiator side of the fabric that feeds the on-chip RAM slave. Booth-multiplier test software uses it to stage operand tables and result buffers without CPU load/store loops. Control comes from a conduit: start pulse, addresses, length, busy/done status.

Parameters:
ADDR_W, 32, width of Avalon byte address and of src/dst inputs
LEN_W, 16, width of word-count input and progress counter
DATA_W, 32, data width; fixed at 32, byteenable width DATA_W/8

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
src_addr  in  ADDR_W  source byte address; bits [1:0] ignored (treated as 0)
dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
len  in  LEN_W  number of 32-bit words to copy
busy  out  1  high from cycle after accepted start until DONE
done  out  1  one-cycle pulse when transfer completes
words_done  out  LEN_W  words fully written in current/last transfer
avm_address  out  ADDR_W  master byte address
avm_read  out  1  read request
avm_write  out  1  write request
avm_byteenable  out  DATA_W/8  constant all-ones
avm_writedata  out  DATA_W  write data
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read data valid
avm_waitrequest  in  1  fabric stall

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, words_done=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0; avm_byteenable=all ones at all times.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: on start=1, latch src (bits[1:0] cleared), dst, len, and clear words_done. If len=0, go to DONE. Otherwise go to RD_REQ. start outside IDLE is ignored (no queueing).
- RD_REQ: avm_read=1, avm_address=current src. Hold the request and address stable while avm_waitrequest=1. The cycle with waitrequest=0 is the acceptance; go to RD_WAIT.
- RD_WAIT: avm_read=0. Wait for avm_readdatavalid=1, capture avm_readdata into a data register, go to WR_REQ. readdatavalid is ignored in every other state. Wait is unbounded; there is no timeout.
- WR_REQ: avm_write=1, avm_address=current dst, avm_writedata=captured word. Hold while waitrequest=1. On acceptance: words_done+1, src+4, dst+4, remaining-1. If remaining becomes 0, go to DONE; otherwise go to RD_REQ.
- avm_read and avm_write are never high together. At most one read is outstanding.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RD_REQ/RD_WAIT/WR_REQ, and 0 in IDLE and DONE.
- Address arithmetic: modulo 2^ADDR_W, wraps silently past all-ones.
- Master outputs are registered; state transitions take one cycle.
- Throughput with waitrequest=0 and read latency 1: 3 cycles per word.
- words_done holds its final value after DONE until the next accepted start.
- Overlapping source/destination ranges: copy is strictly ascending word by word. No overlap protection.
- Reset asserted mid-transfer: immediate abort to IDLE, all outputs at reset values. A partially written destination is left as-is.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, release, 10 idle cycles -> busy=0, done=0, avm_read=avm_write=0, avm_byteenable=4'hF throughout.
- Basic copy: memory model with latency 1, no waitrequest, src=0x0000, dst=0x0100, len=4, words 0xA1..0xA4; start at cycle 0 -> read at cycle 1, reads at 0x0/0x4/0x8/0xC, writes at 0x100..0x10C with matching data; done at cycle 13; words_done=4.
- Backpressure: same copy with waitrequest=1 for 2 cycles on every request -> address/read/write/writedata held stable across stalls; data correct; done at cycle 13+16=29.
- Zero length and busy start: len=0 start -> done pulses the next cycle, no bus activity. start pulses during a len=3 copy -> ignored; exactly 3 writes.
- Misaligned and wrap: src=0x0000_0003 -> first read at 0x0. dst=0xFFFF_FFFC, len=2 -> writes at 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-op: reset_n=0 during WR_REQ of word 2 of 5 -> avm_write drops immediately (asynchronous), busy=0, words_done=0. A new start after release copies from the newly latched addresses.
